// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data-memory access unit.
//   mau_state_e         : access FSM states (IDLE / ISSUE / WAIT / RESP)
//   OP_LD / OP_ST       : request op encoding (req_is_st value)
//   MAU_DEFAULT_TIMEOUT : default load wait limit (used with MAU_TIMEOUT_EN)
package mem_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } mau_state_e;

   localparam logic OP_LD = 1'b0;
   localparam logic OP_ST = 1'b1;

   localparam int unsigned MAU_DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response handshake plus DM pin bundle.
//   req_*      : load/store request from the execute/memory stage
//   rsp_*      : registered response back to the pipeline
//   stall      : pipeline hold while an access is in flight
//   mem_*      : DM ena/wea/addra/dina/douta/done pins
// Modports: slave = the access unit, master = pipeline + memory side.
interface mem_access_unit_if #(
   parameter int unsigned N = 7
) ();

   logic          req_valid;
   logic          req_ready;
   logic          req_is_st;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          stall;
   logic          mem_ena;
   logic          mem_wea;
   logic [N-1:0]  mem_addra;
   logic [31:0]   mem_dina;
   logic [31:0]   mem_douta;
   logic          mem_done;

   modport slave (
      input  req_valid, req_is_st, req_addr, req_wdata, rsp_ready,
             mem_douta, mem_done,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
             mem_ena, mem_wea, mem_addra, mem_dina
   );

   modport master (
      output req_valid, req_is_st, req_addr, req_wdata, rsp_ready,
             mem_douta, mem_done,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
             mem_ena, mem_wea, mem_addra, mem_dina
   );

endinterface

// File: rtl/mau_addr_check.sv
// mau_addr_check: combinational byte-address check for the DM access unit.
//   addr_i      : 32-bit byte address
//   word_addr_o : DM word address (addr_i[N+1:2])
//   err_o       : 1 when the address is not word aligned or lies beyond 2^N words
module mau_addr_check #(
   parameter int unsigned N = 7
) (
   input  logic [31:0]  addr_i,
   output logic [N-1:0] word_addr_o,
   output logic         err_o
);

   always_comb begin
      word_addr_o = addr_i[N+1:2];
      err_o       = (addr_i[1:0] != 2'b00) || (addr_i[31:N+2] != '0);
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for the single-port data memory (DM).
// Accepts one load/store per handshake, issues a one-cycle DM access, waits
// for DM done on loads and returns a registered response; stall is high
// whenever the unit is busy.
//   clka, rst_n : clock, asynchronous active-low reset
//   bus (slave) : req_* / rsp_* / stall pipeline side, mem_* DM pins
// Parameters: N (DM word-address width), TIMEOUT (load wait limit).
// Optional feature: define MAU_TIMEOUT_EN to bound the load wait by TIMEOUT
// cycles; an expired wait answers with rsp_err = 1 and rsp_rdata = 0.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned N       = 7,
   parameter int unsigned TIMEOUT = MAU_DEFAULT_TIMEOUT
) (
   input  logic          clka,
   input  logic          rst_n,
   mem_access_unit_if.slave bus
);

   if (N < 1 || N > 29) begin : g_bad_n
      $error("mem_access_unit: N must be in 1..29");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_access_unit: TIMEOUT must be at least 1");
   end

   mau_state_e   state_q, state_d;
   logic         op_q, op_d;
   logic         req_ready_q, req_ready_d;
   logic         stall_q, stall_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic         rsp_err_q, rsp_err_d;
   logic [31:0]  rsp_rdata_q, rsp_rdata_d;
   logic         mem_ena_q, mem_ena_d;
   logic         mem_wea_q, mem_wea_d;
   logic [N-1:0] mem_addra_q, mem_addra_d;
   logic [31:0]  mem_dina_q, mem_dina_d;

   logic [N-1:0] word_addr;
   logic         addr_err;
   logic         expired;

   mau_addr_check #(.N(N)) u_addr_check (
      .addr_i      (bus.req_addr),
      .word_addr_o (word_addr),
      .err_o       (addr_err)
   );

`ifdef MAU_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Compared before the increment: the wait ends on the edge at which the
   // count of elapsed WAIT cycles reaches TIMEOUT.
   assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_ISSUE) begin
         cnt_d = '0;
      end else if (state_q == S_WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign expired = 1'b0;
`endif

   // State register
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; done (and expiry) only matter in WAIT, done wins
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               state_d = addr_err ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = (op_q == OP_LD) ? S_WAIT : S_RESP;
         end
         S_WAIT: begin
            if (bus.mem_done || expired) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs, keyed off the
   // upcoming state so every output changes on the same edge as the state.
   always_comb begin
      op_d        = op_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_addra_d = mem_addra_q;
      mem_dina_d  = mem_dina_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               op_d        = bus.req_is_st;
               rsp_rdata_d = '0;
               rsp_err_d   = addr_err;
               if (!addr_err) begin
                  mem_addra_d = word_addr;
                  mem_dina_d  = bus.req_wdata;
               end
            end
         end
         S_WAIT: begin
            if (bus.mem_done) begin
               rsp_rdata_d = bus.mem_douta;
               rsp_err_d   = 1'b0;
            end else if (expired) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
            end
         end
         default: ;
      endcase

      req_ready_d = (state_d == S_IDLE);
      stall_d     = (state_d != S_IDLE);
      rsp_valid_d = (state_d == S_RESP);
      mem_ena_d   = (state_d == S_ISSUE);
      mem_wea_d   = (state_d == S_ISSUE) && (op_d == OP_ST);
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= OP_LD;
         req_ready_q <= 1'b1;
         stall_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         mem_ena_q   <= 1'b0;
         mem_wea_q   <= 1'b0;
         mem_addra_q <= '0;
         mem_dina_q  <= '0;
      end else begin
         op_q        <= op_d;
         req_ready_q <= req_ready_d;
         stall_q     <= stall_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_ena_q   <= mem_ena_d;
         mem_wea_q   <= mem_wea_d;
         mem_addra_q <= mem_addra_d;
         mem_dina_q  <= mem_dina_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.stall     = stall_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_ena   = mem_ena_q;
   assign bus.mem_wea   = mem_wea_q;
   assign bus.mem_addra = mem_addra_q;
   assign bus.mem_dina  = mem_dina_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side controller for the single-port data memory (`DM`). It sits in the MEM stage of the SimpleRISC pipeline and accepts one load or store per handshake from the execute/memory stage. It drives the memory's `ena`/`wea`/`addra`/`dina` pins, waits for the memory's `done` on loads, and returns a registered response. While an access is in flight it holds the pipeline with a stall output.

## Interface
- `N`, 7: memory word-address width; must match the `DM` instance.
- `TIMEOUT`, 15: maximum wait cycles for `done` on a load. Used only when `MAU_TIMEOUT_EN` is defined.

Ports:
- `clka` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle if `req_valid` is also high.
- `req_is_st` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: load data; 0 for stores and errors.
- `rsp_err` out 1: access faulted.
- `stall` out 1: high whenever the unit is not in IDLE.
- `mem_ena` out 1, `mem_wea` out 1, `mem_addra` out N, `mem_dina` out 32: drive `DM` `ena`, `wea`, `addra`, `dina`.
- `mem_douta` in 32, `mem_done` in 1: from `DM` `douta`, `done`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch op, address and data.
  - If `req_addr[1:0] != 0` or `req_addr[31:N+2] != 0`: go to RESP with `rsp_err` = 1. No memory access occurs.
  - Otherwise go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `mem_ena` = 1, `mem_wea` = op, `mem_addra` = `req_addr[N+1:2]`, `mem_dina` = store data.
  - Store: go to RESP. `DM` returns no `done` for writes.
  - Load: go to WAIT.
- **WAIT**
  - `mem_ena` = 0.
  - On `mem_done` = 1, capture `mem_douta` into `rsp_rdata` and go to RESP.
- **RESP**
  - `rsp_valid` = 1; hold data and error stable until `rsp_ready`.
  - On `rsp_ready`, return to IDLE. A new request is not accepted in the same cycle.
- `mem_done` is ignored in every state except WAIT.
- All memory-side outputs are registered. `mem_ena` is never high for more than one consecutive cycle.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready` = 1.
  - `rsp_valid`, `rsp_err`, `stall`, `mem_ena`, `mem_wea` = 0.
  - `rsp_rdata`, `mem_addra`, `mem_dina` = 0.
- Let E0 be the accepting edge. Then:
  - `mem_ena` is high E0→E1.
  - Store: `rsp_valid` high from E1. `DM` is written at E1.
  - Load: `DM` raises `done` after E1; the unit captures it at E2; `rsp_valid` high from E2.
  - Misaligned or out-of-range request: `rsp_valid` high from E0.
- Back-to-back throughput with `rsp_ready` tied high:
  - Store: 1 request per 3 cycles.
  - Load: 1 request per 4 cycles.
- `stall` = (state != IDLE), registered.
- Reset mid-operation: the unit returns to IDLE immediately and drops all outputs to their reset values. A late `mem_done` from `DM` is ignored.

## Configuration
- `MAU_TIMEOUT_EN` defined:
  - A 4-bit-minimum counter (`$clog2(TIMEOUT+1)` bits) clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without `mem_done`, go to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - `mem_done` in the same cycle as expiry wins: the response is good data.
- `MAU_TIMEOUT_EN` undefined: no counter; WAIT lasts until `mem_done`, with no limit.

## Structure
- Shared package `mem_pkg`:
  - State enum (IDLE/ISSUE/WAIT/RESP).
  - Op encoding constants `OP_LD` = 0, `OP_ST` = 1.
  - Default `TIMEOUT`.
- One sub-module, `mau_addr_check`: combinational check of alignment and range, producing word address and error flag.

## Test plan
- Store 0xDEADBEEF to 0x0000_0010: `mem_ena`/`mem_wea` high for one cycle with `mem_addra` = 4 and `mem_dina` = 0xDEADBEEF; `rsp_valid` 1 cycle after accept, `rsp_err` = 0.
- Load 0x0000_0010 after that store: `rsp_valid` 2 cycles after accept with `rsp_rdata` = 0xDEADBEEF.
- Load 0x0000_0013 (misaligned) and load 0x0000_0200 (out of range, N = 7): `rsp_err` = 1 in the cycle after accept, and `mem_ena` never asserts.
- `rsp_ready` held low 5 cycles on a load response: `rsp_valid`/`rsp_rdata` stable, `req_ready` = 0, `stall` = 1 throughout.
- Assert `rst_n` low in WAIT while the `DM` model still returns `done`: outputs read reset values, and no `rsp_valid` appears after release.
- With `MAU_TIMEOUT_EN` and `TIMEOUT` = 15, a `DM` stub that never raises `done`: `rsp_err` = 1 and `rsp_rdata` = 0, 15 WAIT cycles after ISSUE.
